// File: rtl/mem_access_unit.sv
// Memory-access stage: drives a req/ready data bus for loads and stores, stalls the
// pipeline while the bus is busy or until a timeout, and registers the W-stage results.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic                  MisalignW,
  output logic                  BusErrW
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;

  logic [1:0] off;
  logic       access, misaligned, aligned_access, mis_access;
  logic       stall, bus_err;

  logic                  regwrite_w_q, regwrite_w_d;
  logic [1:0]            result_src_w_q, result_src_w_d;
  logic [4:0]            rd_w_q, rd_w_d;
  logic [DATA_WIDTH-1:0] alu_result_w_q, alu_result_w_d;
  logic [DATA_WIDTH-1:0] read_data_w_q, read_data_w_d;
  logic [DATA_WIDTH-1:0] pc_plus4_w_q, pc_plus4_w_d;
  logic                  misalign_w_q, misalign_w_d;
  logic                  bus_err_w_q, bus_err_w_d;

  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [2:0]            f3,
    input logic [1:0]            ofs,
    input logic [DATA_WIDTH-1:0] rdata
  );
    logic        [7:0]            b;
    logic        [15:0]           h;
    logic signed [DATA_WIDTH-1:0] sext;
    logic        [DATA_WIDTH-1:0] res;
    b    = rdata[{ofs, 3'b000} +: 8];
    h    = rdata[{ofs[1], 4'b0000} +: 16];
    sext = '0;
    res  = rdata;
    case (f3)
      3'b000: begin
        sext = DATA_WIDTH'(signed'(b));
        res  = sext;
      end
      3'b001: begin
        sext = DATA_WIDTH'(signed'(h));
        res  = sext;
      end
      3'b100:  res = DATA_WIDTH'(b);
      3'b101:  res = DATA_WIDTH'(h);
      default: res = rdata;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   return 4'b0001 << ofs;
      2'b01:   return 4'b0011 << ofs;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate their data so every byte lane carries it.
  function automatic logic [DATA_WIDTH-1:0] store_data(
    input logic [1:0]            size,
    input logic [DATA_WIDTH-1:0] wd
  );
    case (size)
      2'b00:   return {(DATA_WIDTH/8){wd[7:0]}};
      2'b01:   return {(DATA_WIDTH/16){wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  always_comb begin
    off            = ALUResultM[1:0];
    access         = MemWriteM || (ResultSrcM == 2'b01);
    misaligned     = ((Funct3M[1:0] == 2'b01) && off[0]) ||
                     ((Funct3M[1:0] == 2'b10) && (off != 2'b00));
    aligned_access = access && !misaligned;
    mis_access     = access && misaligned && (state_q == IDLE);
  end

  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign mem_be    = store_be(Funct3M[1:0], off);
  assign mem_wdata = store_data(Funct3M[1:0], WriteDataM);
  assign StallM    = stall;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mem_req = 1'b0;
    stall   = 1'b0;
    bus_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aligned_access) begin
          mem_req = 1'b1;
          if (!mem_ready) begin
            stall   = 1'b1;
            state_d = WAIT;
            count_d = '0;
          end
        end
      end
      WAIT: begin
        if (count_q == TIMEOUT_CNT) begin
          // Request withdrawn; a late mem_ready in this cycle is ignored.
          bus_err = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            stall   = 1'b1;
            count_d = count_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      stall   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // M -> W boundary: stalled cycles insert a bubble and keep the data fields.
  always_comb begin
    regwrite_w_d   = 1'b0;
    result_src_w_d = result_src_w_q;
    rd_w_d         = rd_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    misalign_w_d   = 1'b0;
    bus_err_w_d    = 1'b0;
    if (!stall) begin
      regwrite_w_d   = RegWriteM && !mis_access && !bus_err;
      result_src_w_d = ResultSrcM;
      rd_w_d         = RdM;
      alu_result_w_d = ALUResultM;
      read_data_w_d  = load_extract(Funct3M, off, mem_rdata);
      pc_plus4_w_d   = PCPlus4M;
      misalign_w_d   = mis_access;
      bus_err_w_d    = bus_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_w_q   <= 1'b0;
      result_src_w_q <= '0;
      rd_w_q         <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus4_w_q   <= '0;
      misalign_w_q   <= 1'b0;
      bus_err_w_q    <= 1'b0;
    end else begin
      regwrite_w_q   <= regwrite_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      misalign_w_q   <= misalign_w_d;
      bus_err_w_q    <= bus_err_w_d;
    end
  end

  assign RegWriteW  = regwrite_w_q;
  assign ResultSrcW = result_src_w_q;
  assign RdW        = rd_w_q;
  assign ALUResultW = alu_result_w_q;
  assign ReadDataW  = read_data_w_q;
  assign PCPlus4W   = pc_plus4_w_q;
  assign MisalignW  = misalign_w_q;
  assign BusErrW    = bus_err_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: randomized loads/stores against a reference model,
// W-stage results checked by a scoreboard monitor on the falling clock edge.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, mem_ready;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, mem_rdata;
  logic        mem_req, mem_we, StallM, RegWriteW, MisalignW, BusErrW;
  logic [3:0]  mem_be;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] mem_addr, mem_wdata, ALUResultW, ReadDataW, PCPlus4W;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] word);
    int unsigned b, h;
    int          s;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'b000: begin s = (b >= 128) ? int'(b) - 256 : int'(b); return 32'(s); end
      3'b001: begin s = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(s); end
      3'b100: return b;
      3'b101: return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
      2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // Monitor: each falling edge sees the W result of the previous cycle.
  bit   have_prev  = 1'b0;
  bit   prev_stall = 1'b0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        if (prev_stall) begin
          chk("bubble_regwrite", 32'(RegWriteW), 32'd0);
          chk("bubble_misalign", 32'(MisalignW), 32'd0);
          chk("bubble_buserr", 32'(BusErrW), 32'd0);
        end else if (q.size() == 0) begin
          chk("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
          e_mon = q.pop_front();
          chk("RegWriteW", 32'(RegWriteW), 32'(e_mon.rw));
          chk("ResultSrcW", 32'(ResultSrcW), 32'(e_mon.rs));
          chk("RdW", 32'(RdW), 32'(e_mon.rd));
          chk("ALUResultW", ALUResultW, e_mon.alu);
          chk("PCPlus4W", PCPlus4W, e_mon.pc4);
          chk("MisalignW", 32'(MisalignW), 32'(e_mon.mis));
          chk("BusErrW", 32'(BusErrW), 32'(e_mon.berr));
          if (e_mon.chk_rdata) chk("ReadDataW", ReadDataW, e_mon.rdata);
        end
      end
      prev_stall = StallM;
      have_prev  = 1'b1;
    end
  end

  task automatic set_idle();
    RegWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    MemWriteM  = 1'b0;
    mem_ready  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_StallM"}, 32'(StallM), 32'd0);
    chk({tag, "_RegWriteW"}, 32'(RegWriteW), 32'd0);
    chk({tag, "_ResultSrcW"}, 32'(ResultSrcW), 32'd0);
    chk({tag, "_RdW"}, 32'(RdW), 32'd0);
    chk({tag, "_ALUResultW"}, ALUResultW, 32'd0);
    chk({tag, "_ReadDataW"}, ReadDataW, 32'd0);
    chk({tag, "_PCPlus4W"}, PCPlus4W, 32'd0);
    chk({tag, "_MisalignW"}, 32'(MisalignW), 32'd0);
    chk({tag, "_BusErrW"}, 32'(BusErrW), 32'd0);
  endtask

  // Entered and left at 1 time unit after a rising edge. The memory answers after
  // 'lat' cycles; the access completes at min(lat, TO+1) with a bus error at TO+1.
  task automatic do_txn(input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input bit fix,
                        input logic [31:0] fixed_rd, output int n_stall);
    logic        acc, mis, load, done, berr, exp_req;
    logic [31:0] pc4;
    int          off, k;
    exp_t        e;
    acc  = mw || (rs == 2'b01);
    load = !mw && (rs == 2'b01);
    off  = int'(addr[1:0]);
    mis  = acc && (((f3[1:0] == 2'b01) && (off % 2 != 0)) || ((f3[1:0] == 2'b10) && (off != 0)));
    pc4  = $urandom;
    n_stall = 0;
    k    = 0;
    done = 1'b0;
    while (!done) begin
      RegWriteM  = rw;
      ResultSrcM = rs;
      MemWriteM  = mw;
      Funct3M    = f3;
      RdM        = rd;
      ALUResultM = addr;
      WriteDataM = wd;
      PCPlus4M   = pc4;
      mem_rdata  = fix ? fixed_rd : $urandom;
      if (acc && !mis) begin
        mem_ready = (k == lat);
        berr      = (k == TO + 1);
        done      = (k == lat) || berr;
        exp_req   = (k <= TO);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        berr      = 1'b0;
        done      = 1'b1;
        exp_req   = 1'b0;
      end
      if (done) begin
        e.rw        = rw && !mis && !berr;
        e.rs        = rs;
        e.rd        = rd;
        e.alu       = addr;
        e.pc4       = pc4;
        e.rdata     = ref_load(f3, off, mem_rdata);
        e.chk_rdata = load && !mis && !berr;
        e.mis       = mis;
        e.berr      = berr;
        q.push_back(e);
      end
      #3;
      if (StallM) n_stall++;
      chk("StallM", 32'(StallM), 32'(!done));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(mw));
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (mw) begin
          chk("mem_be", 32'(mem_be), 32'(ref_be(f3, off)));
          chk("mem_wdata", mem_wdata, ref_wdata(f3, wd));
        end
      end
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    int          ns;
    int          kind, lat;
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic        mw;

    rst = 1'b0;
    set_idle();
    Funct3M = 3'b010; RdM = '0; ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0;
    mem_rdata = '0;
    #1 rst = 1'b1;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h100;
    #1;
    chk_reset_outputs("reset0");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset1");
    set_idle();
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait LW
    do_txn(1'b1, 2'b01, 1'b0, 3'b010, 5'd5, 32'h100, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, ns);
    chk("lw_nostall", 32'(ns), 32'd0);
    chk("lw_rdata", ReadDataW, 32'hDEAD_BEEF);
    chk("lw_regwrite", 32'(RegWriteW), 32'd1);

    // LB with three stalled cycles
    do_txn(1'b1, 2'b01, 1'b0, 3'b000, 5'd7, 32'h103, 32'h0, 3, 1'b1, 32'h80FF_FFFF, ns);
    chk("lb_stall_cycles", 32'(ns), 32'd3);
    chk("lb_sext", ReadDataW, 32'hFFFF_FF80);

    // SH to upper half: lanes checked while the store is still presented
    do_txn(1'b0, 2'b00, 1'b1, 3'b001, 5'd0, 32'h102, 32'h0000_BEEF, 0, 1'b0, 32'h0, ns);
    chk("sh_be", 32'(mem_be), 32'h0000_000C);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(mem_we), 32'd1);

    // Misaligned LW
    do_txn(1'b1, 2'b01, 1'b0, 3'b010, 5'd9, 32'h101, 32'h0, 0, 1'b0, 32'h0, ns);
    chk("mis_pulse", 32'(MisalignW), 32'd1);
    chk("mis_regwrite", 32'(RegWriteW), 32'd0);

    // Timeout
    do_txn(1'b1, 2'b01, 1'b0, 3'b010, 5'd3, 32'h200, 32'h0, 50, 1'b0, 32'h0, ns);
    chk("to_stall_cycles", 32'(ns), 32'(TO + 1));
    chk("to_buserr", 32'(BusErrW), 32'd1);
    chk("to_regwrite", 32'(RegWriteW), 32'd0);

    // Reset in the middle of a wait
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
    RdM = 5'd4; ALUResultM = 32'h300; mem_ready = 1'b0;
    #3 chk("pre_rst_stall", 32'(StallM), 32'd1);
    @(posedge clk);
    #1;
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midwait");
    set_idle();
    @(posedge clk);
    #1 rst = 1'b0;
    do_txn(1'b1, 2'b01, 1'b0, 3'b010, 5'd6, 32'h104, 32'h0, 0, 1'b1, 32'h1234_5678, ns);
    chk("post_rst_nostall", 32'(ns), 32'd0);
    chk("post_rst_rdata", ReadDataW, 32'h1234_5678);
    chk("post_rst_regwrite", 32'(RegWriteW), 32'd1);

    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(0, TO + 2));
      case (kind)
        0: begin
          mw = 1'b0; rs = 2'b01;
          f3 = load_f3[$urandom_range(0, 4)];
        end
        1: begin
          mw = 1'b1; rs = 2'($urandom_range(0, 3));
          f3 = 3'($urandom_range(0, 2));
        end
        default: begin
          mw = 1'b0;
          rs = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
          f3 = 3'($urandom_range(0, 7));
        end
      endcase
      do_txn(1'($urandom_range(0, 1)), rs, mw, f3, 5'($urandom), $urandom, $urandom,
             lat, 1'b0, 32'h0, ns);
    end

    do_txn(1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 0, 1'b0, 32'h0, ns);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
